// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: byte handshake and serial line between a byte producer
// (master) and the UART transmitter (slave). The producer drives
// transmit_byte/tran_data and watches tx_busy to pace itself. The transmitter
// drives tx_busy and the serial line tx.
interface uart_transmitter_if;
  logic [7:0] transmit_byte;
  logic       tran_data;
  logic       tx_busy;
  logic       tx;

  // Byte producer side
  modport master (
    output transmit_byte,
    output tran_data,
    input  tx_busy,
    input  tx
  );

  // Transmitter side
  modport slave (
    input  transmit_byte,
    input  tran_data,
    output tx_busy,
    output tx
  );
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: sends one byte per accepted request as an LSB-first UART
// frame.
//   Default build      : 8N1 (start, 8 data, stop) = 10 bit periods.
//   TX_PARITY_EN macro : 8E1 (start, 8 data, even parity, stop) = 11 bit periods.
// A request is accepted only from IDLE. tx and tx_busy are registered and
// change on the accepting edge. Reset is asynchronous and active-low. It drops
// any frame in flight and returns the line to idle-high at once.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clock,
  input  logic              reset,
  uart_transmitter_if.slave tx_if
);

  // Baud counter sizing: counts 0..CLKS_PER_BIT-1
  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  // Frame state encoding
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg,   cnt_next;
  logic [2:0]    idx_reg,   idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg,    tx_next;
  logic          busy_reg,  busy_next;
`ifdef TX_PARITY_EN
  logic          parity_reg, parity_next;
`endif

  // End of the current bit period: the counter is on its last count
  logic bit_end;
  assign bit_end = (cnt_reg == CNT_MAX);

  // Outputs come straight from registers, so they are glitch-free
  assign tx_if.tx      = tx_reg;
  assign tx_if.tx_busy = busy_reg;

  // Next-state logic: baud timing, bit sequencing and line value
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
`ifdef TX_PARITY_EN
    parity_next = parity_reg;
`endif

    // The counter runs in every non-idle state. A bit end wraps it to 0, and
    // every state change happens on a bit end, so each new state starts from 0.
    if (state_reg != IDLE) begin
      cnt_next = bit_end ? '0 : cnt_reg + CW'(1);
    end

    case (state_reg)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (tx_if.tran_data) begin
          // Accept: the start bit goes onto the line at this same edge
          shift_next = tx_if.transmit_byte;
          cnt_next   = '0;
          idx_next   = 3'd0;
          busy_next  = 1'b1;
          tx_next    = 1'b0;
          state_next = START;
`ifdef TX_PARITY_EN
          parity_next = ^tx_if.transmit_byte;
`endif
        end
      end

      START: begin
        if (bit_end) begin
          tx_next    = shift_reg[0];
          idx_next   = 3'd0;
          state_next = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          shift_next = {1'b0, shift_reg[7:1]};
          if (idx_reg == 3'd7) begin
            // Last data bit done. The index stays at 7 and does not wrap.
`ifdef TX_PARITY_EN
            tx_next    = parity_reg;
            state_next = PARITY;
`else
            tx_next    = 1'b1;
            state_next = STOP;
`endif
          end else begin
            // The next LSB is the bit that the shift moves into position 0
            idx_next = idx_reg + 3'd1;
            tx_next  = shift_reg[1];
          end
        end
      end

`ifdef TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          tx_next    = 1'b1;
          state_next = STOP;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          // Busy drops here, so a request in the next cycle starts back-to-back
          tx_next    = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        // Unreachable encodings recover to a quiet idle line
        state_next = IDLE;
        cnt_next   = '0;
        idx_next   = 3'd0;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset (truncates any frame)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= 3'd0;
      shift_reg <= 8'd0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
    end
  end

`ifdef TX_PARITY_EN
  // Even-parity bit for the frame in flight, captured at acceptance
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parity_reg <= 1'b0;
    end else begin
      parity_reg <= parity_next;
    end
  end
`endif

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench for uart_transmitter (CLKS_PER_BIT = 4).
// The driver pushes each byte that should go on the line into exp_q. A
// UART-receiver monitor decodes tx at mid-bit points, pops exp_q and compares.
// A second monitor checks the tx_busy high time of each frame.
module tb_uart_transmitter;
  localparam int N = 4;
`ifdef TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * N;

  logic clk;
  logic rst_n;
  uart_transmitter_if u_if();

  uart_transmitter #(.CLKS_PER_BIT(N)) dut (
    .clock (clk),
    .reset (rst_n),
    .tx_if (u_if)
  );

  int errors = 0;
  int checks = 0;
  int frames = 0;
  logic [7:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Receiver monitor: decode one frame from its first start-bit cycle
  task automatic decode_frame();
    logic [10:0] fb;
    logic [7:0]  data;
    logic [7:0]  exp;
    bit          aborted;
    fb = '0;
    aborted = 0;
    for (int c = 1; c <= (FRAME_BITS - 1) * N + N / 2; c++) begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        aborted = 1;
        break;
      end
      if (c % N == N / 2) fb[c / N] = u_if.tx;
    end
    if (aborted) begin
      $display("frame truncated by reset at %0t", $time);
    end else begin
      data = fb[8:1];
      chk("start_bit", 32'(fb[0]), 32'h0);
      chk("stop_bit", 32'(fb[FRAME_BITS-1]), 32'h1);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got 0x%02h expected no frame", data);
      end else begin
        exp = exp_q.pop_front();
        if (data !== exp) begin
          errors++;
          $display("FAIL frame_data: got 0x%02h expected 0x%02h", data, exp);
        end
`ifdef TX_PARITY_EN
        chk("parity_bit", 32'(fb[9]), 32'(^exp));
`endif
        $display("frame %0d: data=0x%02h expected=0x%02h", frames, data, exp);
      end
      frames++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && u_if.tx === 1'b0) decode_frame();
    end
  end

  // Busy-length monitor: each complete frame keeps tx_busy high for FRAME_CYC cycles
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        busy_cnt = 0;
      end else if (u_if.tx_busy === 1'b1) begin
        busy_cnt++;
      end else if (busy_cnt != 0) begin
        chk("busy_len", 32'(busy_cnt), 32'(FRAME_CYC));
        busy_cnt = 0;
      end
    end
  end

  // Wait (bounded) at negedges until the transmitter is idle
  task automatic wait_idle();
    int n;
    n = 0;
    while (u_if.tx_busy !== 1'b0 && n < 4 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    if (u_if.tx_busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy=%b expected 0 within %0d cycles", u_if.tx_busy, 4 * FRAME_CYC);
    end
  endtask

  // Issue one request from idle; returns at the negedge after acceptance
  task automatic send_byte(input logic [7:0] b, input bit expect_frame);
    wait_idle();
    u_if.transmit_byte = b;
    u_if.tran_data = 1'b1;
    if (expect_frame) exp_q.push_back(b);
    @(negedge clk);
    u_if.tran_data = 1'b0;
    chk("accept_busy", 32'(u_if.tx_busy), 32'h1);
    chk("accept_start", 32'(u_if.tx), 32'h0);
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    u_if.tran_data = 1'b0;
    u_if.transmit_byte = 8'h00;

    // Reset and quiet idle
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(u_if.tx), 32'h1);
    chk("reset_busy", 32'(u_if.tx_busy), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_tx", 32'(u_if.tx), 32'h1);
      chk("idle_busy", 32'(u_if.tx_busy), 32'h0);
    end

    // Single byte 0x55
    send_byte(8'h55, 1);

    // Busy-ignore: a 0xFF request mid-frame must not be sent
    send_byte(8'hA3, 1);
    repeat (10) @(negedge clk);
    u_if.transmit_byte = 8'hFF;
    u_if.tran_data = 1'b1;
    @(negedge clk);
    u_if.tran_data = 1'b0;

    // Back-to-back: tran_data held high, byte switched at the busy fall
    wait_idle();
    u_if.transmit_byte = 8'h01;
    u_if.tran_data = 1'b1;
    exp_q.push_back(8'h01);
    @(negedge clk);
    chk("b2b_first_busy", 32'(u_if.tx_busy), 32'h1);
    r = 0;
    while (u_if.tx_busy !== 1'b0 && r < 2 * FRAME_CYC) begin
      @(negedge clk);
      r++;
    end
    u_if.transmit_byte = 8'h80;
    exp_q.push_back(8'h80);
    @(negedge clk);
    chk("b2b_gap_one_cycle", 32'(u_if.tx_busy), 32'h1);
    chk("b2b_start", 32'(u_if.tx), 32'h0);
    u_if.tran_data = 1'b0;

    // Reset during data bit 3 of 0x0F, then a clean resend
    send_byte(8'h0F, 0);
    repeat (4 * N + 1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_tx", 32'(u_if.tx), 32'h1);
    chk("midreset_busy", 32'(u_if.tx_busy), 32'h0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h0F, 1);

    // Randomized traffic with ignored mid-frame requests and byte changes
    for (int i = 0; i < 20; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, FRAME_CYC - 4)) @(negedge clk);
        u_if.transmit_byte = 8'($urandom_range(0, 255));
        u_if.tran_data = 1'b1;
        @(negedge clk);
        u_if.tran_data = 1'b0;
        u_if.transmit_byte = 8'($urandom_range(0, 255));
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Drain the scoreboard (bounded)
    r = 0;
    while ((exp_q.size() != 0 || u_if.tx_busy !== 1'b0) && r < 4 * FRAME_CYC) begin
      @(negedge clk);
      r++;
    end
    repeat (N) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
